pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the OpenMIPS core. It replaces free-running pipeline registers with a centrally driven stall/flush scheme. It collects per-stage stall requests and exception/redirect flush requests. It drives a per-stage stall vector, a multi-cycle flush with redirect PC, a saturating stall-cycle performance counter and a stall watchdog. It sits beside pc_reg and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which consume stall_o/flush_o.

Parameters:
NSTAGES, 6, number of controlled stages; bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = wb
ADDR_W, 32, redirect PC width (matches InstAddrBus)
FLUSH_CYC, 1, cycles flush_o is held per accepted flush; legal range >= 1
CNT_W, 32, stall performance counter width
WDOG_CYC, 1024, consecutive-stall threshold for the watchdog; 0 disables it

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stallreq_i  in  NSTAGES  bit k = stage k requests a stall this cycle
flush_req_i  in  1  exception/redirect request
flush_pc_i  in  ADDR_W  redirect target, sampled with flush_req_i
stall_o  out  NSTAGES  bit k = stage k holds its register
flush_o  out  1  all pipeline registers load bubbles
new_pc_o  out  ADDR_W  redirect PC for pc_reg
new_pc_valid_o  out  1  one-cycle strobe: pc_reg loads new_pc_o
stall_cnt_o  out  CNT_W  count of cycles with any stall_o bit set
wdog_o  out  1  one-cycle pulse on stall watchdog expiry
busy_o  out  1  high while in FLUSH state

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, flush counter=0, captured pc=0, stall_cnt_o=0, watchdog counter=0, wdog_o=0. While rst=1 all combinational outputs (stall_o, flush_o, new_pc_o, new_pc_valid_o, busy_o) are forced to 0. Reset overrides any operation in progress, including a flush mid-sequence.
- Stall vector (combinational, zero latency): let h = index of the highest set bit of stallreq_i. Then stall_o[k]=1 for k<=h and 0 for k>h. stall_o=0 if stallreq_i=0. Stage h+1 inserts a bubble (its register sees stall_o[h]=1, stall_o[h+1]=0).
- Priority: flush over stall. Whenever flush_o=1, stall_o is forced to 0.
- States: IDLE, FLUSH.
- IDLE, flush_req_i=1 in cycle t:
  - flush_o=1, new_pc_o=flush_pc_i, new_pc_valid_o=1 in cycle t, combinationally.
  - flush_pc_i is captured.
  - If FLUSH_CYC>1: go to FLUSH with counter=FLUSH_CYC-1. Otherwise stay in IDLE.
- FLUSH:
  - flush_o=1, busy_o=1, new_pc_o=captured pc, new_pc_valid_o=0.
  - Counter decrements each cycle; return to IDLE after the cycle in which counter==1.
  - Total flush_o assertion is exactly FLUSH_CYC consecutive cycles.
- flush_req_i while in FLUSH: restart. Act as the IDLE acceptance in that cycle (new pc, strobe, counter reloaded to FLUSH_CYC-1). If FLUSH_CYC=1, go to IDLE.
- new_pc_o=0 when not flushing.
- stall_cnt_o: +1 at each edge where stall_o!=0 in the preceding cycle. Saturates at 2^CNT_W-1 and never wraps.
- Watchdog:
  - A counter increments while stall_o!=0 and clears to 0 on any cycle with stall_o=0 or flush_o=1.
  - When it reaches WDOG_CYC, wdog_o=1 for the next cycle and the counter clears. Continued stalling re-arms it, so there is one pulse per WDOG_CYC stall cycles.
  - If WDOG_CYC=0, wdog_o stays 0.
- stallreq_i bits >= NSTAGES do not exist. All arithmetic is unsigned. Counter widths are $clog2-sized, minimum 1.

Decomposition:
- Add to defines.v: stage index constants (`StagePc … `StageWb), `Stop/`NoStop, `Flush/`NoFlush.
- One natural sub-module, pipe_sat_cnt: parametrised saturating counter with clear. It is used for stall_cnt_o and the watchdog counter.
- The FSM, priority logic and stall-vector encoder stay in pipe_ctrl.

Test Plan:
- Reset: hold rst 2 cycles with stallreq_i=6'b001000 and flush_req_i=1 -> all outputs 0 during reset; stall_cnt_o=0 after release.
- Stall encode: stallreq_i=6'b000100 (id_ex) -> stall_o=6'b000111 in the same cycle. stallreq_i=6'b010010 -> stall_o=6'b011111. 3 stall cycles -> stall_cnt_o=3.
- Flush FLUSH_CYC=3: flush_req_i pulse with flush_pc_i=32'h0000_0140 -> flush_o high 3 cycles, new_pc_valid_o high first cycle only, new_pc_o=32'h140 for all 3 cycles, busy_o high cycles 2–3.
- Flush vs stall: stallreq_i=6'b001111 with flush_req_i=1 -> stall_o=0, flush_o=1, and stall_cnt_o is unchanged.
- Restart: FLUSH_CYC=3, second flush_req_i (pc 32'h200) in the 2nd flush cycle -> flush_o high 4 cycles total, second strobe, new_pc_o=32'h200 thereafter.
- Watchdog/saturation: WDOG_CYC=4 with stallreq_i held 9 cycles -> wdog_o pulses after the 4th and 8th stall cycles. CNT_W=3 with 10 stall cycles -> stall_cnt_o=7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Stage indices into the stall vector
  localparam int STAGE_PC    = 0;
  localparam int STAGE_IF_ID = 1;
  localparam int STAGE_ID_EX = 2;
  localparam int STAGE_EX_MM = 3;
  localparam int STAGE_MM_WB = 4;
  localparam int STAGE_WB    = 5;

  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;
  localparam logic FLUSH    = 1'b1;
  localparam logic NO_FLUSH = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline and its stall/flush controller.
interface pipe_ctrl_if #(
  parameter int NSTAGES = 6,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
);
  logic [NSTAGES-1:0] stallreq;
  logic               flush_req;
  logic [ADDR_W-1:0]  flush_pc;
  logic [NSTAGES-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               new_pc_valid;
  logic [CNT_W-1:0]   stall_cnt;
  logic               wdog;
  logic               busy;

  // Pipeline side: raises requests, consumes stall/flush controls
  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, flush, new_pc, new_pc_valid, stall_cnt, wdog, busy
  );

  // Controller side
  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, flush, new_pc, new_pc_valid, stall_cnt, wdog, busy
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module pipe_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up until saturated, clear on request
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
//
// state    | meaning
// ST_IDLE  | no flush in progress; flush_req is accepted combinationally
// ST_FLUSH | holding flush for the remaining cycles of a multi-cycle flush
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES   = 6,
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32,
  parameter int WDOG_CYC  = 1024
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam int FC_W = cnt_width(FLUSH_CYC);
  localparam int WD_W = cnt_width(WDOG_CYC + 1);
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'((FLUSH_CYC > 1) ? FLUSH_CYC - 1 : 0);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);

  state_t             state;
  logic [FC_W-1:0]    fcnt;
  logic [ADDR_W-1:0]  cap_pc;

  logic               seen;
  logic [NSTAGES-1:0] stall_enc;
  logic               flush_on;
  logic [NSTAGES-1:0] stall_vec;
  logic               flush_act;
  logic [ADDR_W-1:0]  pc_sel;
  logic               pc_strobe;
  logic               in_flush;
  logic               stall_any;

  logic [CNT_W-1:0]   stall_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_expire;
  logic               wdog_q;

  // Every stage at or below the highest requester holds
  always_comb begin
    seen      = 1'b0;
    stall_enc = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      seen         = seen | bus.stallreq[k];
      stall_enc[k] = seen;
    end
  end

  assign flush_on = bus.flush_req | (state == ST_FLUSH);

  // Output muxing: reset blanks everything, flush overrides stall
  always_comb begin
    stall_vec = '0;
    flush_act = 1'b0;
    pc_sel    = '0;
    pc_strobe = 1'b0;
    in_flush  = 1'b0;
    if (!rst) begin
      flush_act = flush_on;
      stall_vec = flush_on ? '0 : stall_enc;
      pc_strobe = bus.flush_req;
      in_flush  = (state == ST_FLUSH);
      if (bus.flush_req) begin
        pc_sel = bus.flush_pc;
      end else if (state == ST_FLUSH) begin
        pc_sel = cap_pc;
      end
    end
  end

  assign stall_any = |stall_vec;

  // Flush sequencer; a new request restarts the sequence from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      fcnt   <= '0;
      cap_pc <= '0;
    end else if (bus.flush_req) begin
      cap_pc <= bus.flush_pc;
      if (FLUSH_CYC > 1) begin
        state <= ST_FLUSH;
        fcnt  <= FC_RELOAD;
      end else begin
        state <= ST_IDLE;
        fcnt  <= '0;
      end
    end else if (state == ST_FLUSH) begin
      if (fcnt == FC_W'(1)) begin
        state <= ST_IDLE;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt - FC_W'(1);
      end
    end
  end

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (stall_any),
    .cnt (stall_cnt)
  );

  // The watchdog run restarts whenever the pipeline moves or a pulse fires
  assign wd_expire = (WDOG_CYC != 0) && stall_any && (wd_cnt == WD_LAST);

  pipe_sat_cnt #(.W(WD_W)) u_wdog_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!stall_any || wd_expire),
    .inc (stall_any),
    .cnt (wd_cnt)
  );

  // One-cycle watchdog pulse, registered
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 1'b0;
    end else begin
      wdog_q <= wd_expire;
    end
  end

  assign bus.stall        = stall_vec;
  assign bus.flush        = flush_act;
  assign bus.new_pc       = pc_sel;
  assign bus.new_pc_valid = pc_strobe;
  assign bus.busy         = in_flush;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.wdog         = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two configurations share one stimulus stream and are
// checked every cycle against a behavioural model plus literal spot checks.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sr;
  logic        fr;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGES(6), .ADDR_W(32), .CNT_W(3)) ifa ();
  pipe_ctrl_if #(.NSTAGES(6), .ADDR_W(32), .CNT_W(8)) ifb ();

  assign ifa.stallreq  = sr;
  assign ifa.flush_req = fr;
  assign ifa.flush_pc  = pc;
  assign ifb.stallreq  = sr;
  assign ifb.flush_req = fr;
  assign ifb.flush_pc  = pc;

  pipe_ctrl #(.NSTAGES(6), .ADDR_W(32), .FLUSH_CYC(3), .CNT_W(3), .WDOG_CYC(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pipe_ctrl #(.NSTAGES(6), .ADDR_W(32), .FLUSH_CYC(1), .CNT_W(8), .WDOG_CYC(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  // Model: per instance, flush cycles still owed after the current one,
  // captured pc, total stalled cycles, current stall run length, wdog pulse.
  int          fcyc[2] = '{3, 1};
  int          wcyc[2] = '{4, 0};
  int          cwid[2] = '{3, 8};
  int          left[2];
  logic [31:0] cap[2];
  longint      scnt[2];
  int          wrun[2];
  logic        wdm[2];
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] mask_of(input logic [5:0] r);
    int h;
    h = -1;
    for (int k = 0; k < 6; k++) if (r[k]) h = k;
    if (h < 0) return 6'd0;
    return 6'((1 << (h + 1)) - 1);
  endfunction

  function automatic logic [5:0] st_exp(input int i);
    if (rst || fr || left[i] > 0) return 6'd0;
    return mask_of(sr);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i] <= 0;
        cap[i]  <= '0;
        scnt[i] <= 0;
        wrun[i] <= 0;
        wdm[i]  <= 1'b0;
      end
      model_ok <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (st_exp(i) != 0 && scnt[i] < (longint'(1) << cwid[i]) - 1) scnt[i] <= scnt[i] + 1;
        if (wcyc[i] != 0 && st_exp(i) != 0) begin
          if (wrun[i] + 1 == wcyc[i]) begin
            wrun[i] <= 0;
            wdm[i]  <= 1'b1;
          end else begin
            wrun[i] <= wrun[i] + 1;
            wdm[i]  <= 1'b0;
          end
        end else begin
          wrun[i] <= 0;
          wdm[i]  <= 1'b0;
        end
        if (fr) begin
          left[i] <= fcyc[i] - 1;
          cap[i]  <= pc;
        end else if (left[i] > 0) begin
          left[i] <= left[i] - 1;
        end
      end
    end
  end

  task automatic cmp(input string t, input int i, input logic [5:0] st, input logic fl,
                     input logic [31:0] np, input logic v, input logic b,
                     input logic [63:0] sc, input logic w);
    logic [31:0] pc_e;
    pc_e = rst ? 32'd0 : (fr ? pc : (left[i] > 0 ? cap[i] : 32'd0));
    chk({t, ".stall"}, st, st_exp(i));
    chk({t, ".flush"}, fl, !rst && (fr || left[i] > 0));
    chk({t, ".new_pc"}, np, pc_e);
    chk({t, ".new_pc_valid"}, v, !rst && fr);
    chk({t, ".busy"}, b, !rst && left[i] > 0);
    chk({t, ".stall_cnt"}, sc, scnt[i]);
    chk({t, ".wdog"}, w, wdm[i]);
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp("a", 0, ifa.stall, ifa.flush, ifa.new_pc, ifa.new_pc_valid, ifa.busy, ifa.stall_cnt, ifa.wdog);
      cmp("b", 1, ifb.stall, ifb.flush, ifb.new_pc, ifb.new_pc_valid, ifb.busy, ifb.stall_cnt, ifb.wdog);
    end
  end

  task automatic cyc(input logic [5:0] s, input logic f, input logic [31:0] p);
    @(posedge clk);
    #1;
    sr = s;
    fr = f;
    pc = p;
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sr  = 6'b001000;
    fr  = 1'b1;
    pc  = 32'hdead_beef;
    repeat (2) begin
      @(negedge clk);
      chk("rst.a.stall", ifa.stall, 64'h0);
      chk("rst.a.flush", ifa.flush, 64'h0);
      chk("rst.a.new_pc", ifa.new_pc, 64'h0);
      chk("rst.a.valid", ifa.new_pc_valid, 64'h0);
      chk("rst.a.busy", ifa.busy, 64'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sr  = '0;
    fr  = 1'b0;
    pc  = '0;
    @(negedge clk);
    chk("rel.a.stall_cnt", ifa.stall_cnt, 64'd0);
    chk("rel.b.stall_cnt", ifb.stall_cnt, 64'd0);

    cyc(6'b000100, 1'b0, 32'h0);
    chk("enc.id_ex", ifa.stall, 64'h07);
    cyc(6'b010010, 1'b0, 32'h0);
    chk("enc.multi", ifa.stall, 64'h1f);
    cyc(6'b100000, 1'b0, 32'h0);
    chk("enc.top", ifa.stall, 64'h3f);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("enc.none", ifa.stall, 64'h00);
    chk("cnt3.a", ifa.stall_cnt, 64'd3);
    chk("cnt3.b", ifb.stall_cnt, 64'd3);

    cyc(6'b000000, 1'b1, 32'h0000_0140);
    chk("fl1.flush", ifa.flush, 64'd1);
    chk("fl1.valid", ifa.new_pc_valid, 64'd1);
    chk("fl1.pc", ifa.new_pc, 64'h140);
    chk("fl1.busy", ifa.busy, 64'd0);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("fl2.flush", ifa.flush, 64'd1);
    chk("fl2.valid", ifa.new_pc_valid, 64'd0);
    chk("fl2.pc", ifa.new_pc, 64'h140);
    chk("fl2.busy", ifa.busy, 64'd1);
    chk("fl2.b.flush", ifb.flush, 64'd0);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("fl3.flush", ifa.flush, 64'd1);
    chk("fl3.pc", ifa.new_pc, 64'h140);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("fl4.flush", ifa.flush, 64'd0);
    chk("fl4.pc", ifa.new_pc, 64'h0);
    chk("fl4.busy", ifa.busy, 64'd0);

    cyc(6'b001111, 1'b1, 32'h0000_0080);
    chk("fvs.stall", ifa.stall, 64'h0);
    chk("fvs.flush", ifa.flush, 64'd1);
    cyc(6'b001111, 1'b0, 32'h0);
    chk("fvs.a.hold", ifa.stall, 64'h0);
    chk("fvs.b.idle", ifb.stall, 64'h0f);
    cyc(6'b000000, 1'b0, 32'h0);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("fvs.a.cnt", ifa.stall_cnt, 64'd3);
    chk("fvs.b.cnt", ifb.stall_cnt, 64'd4);

    cyc(6'b000000, 1'b1, 32'h0000_0100);
    chk("rs1.pc", ifa.new_pc, 64'h100);
    cyc(6'b000000, 1'b1, 32'h0000_0200);
    chk("rs2.valid", ifa.new_pc_valid, 64'd1);
    chk("rs2.pc", ifa.new_pc, 64'h200);
    chk("rs2.busy", ifa.busy, 64'd1);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("rs3.flush", ifa.flush, 64'd1);
    chk("rs3.valid", ifa.new_pc_valid, 64'd0);
    chk("rs3.pc", ifa.new_pc, 64'h200);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("rs4.flush", ifa.flush, 64'd1);
    chk("rs4.pc", ifa.new_pc, 64'h200);
    cyc(6'b000000, 1'b0, 32'h0);
    chk("rs5.flush", ifa.flush, 64'd0);

    for (int i = 0; i < 9; i++) begin
      cyc(6'b000010, 1'b0, 32'h0);
      chk($sformatf("wd.%0d", i), ifa.wdog, (i == 4 || i == 8) ? 64'd1 : 64'd0);
    end
    cyc(6'b000000, 1'b0, 32'h0);
    chk("wd.end", ifa.wdog, 64'd0);
    chk("sat.a", ifa.stall_cnt, 64'd7);
    chk("sat.b", ifb.stall_cnt, 64'd13);

    cyc(6'b000000, 1'b1, 32'h0000_0300);
    chk("rmf.flush", ifa.flush, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fr  = 1'b0;
    @(negedge clk);
    chk("rmf.rst.flush", ifa.flush, 64'd0);
    chk("rmf.rst.busy", ifa.busy, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmf.after.flush", ifa.flush, 64'd0);
    chk("rmf.after.busy", ifa.busy, 64'd0);
    chk("rmf.after.cnt", ifa.stall_cnt, 64'd0);
    cyc(6'b000000, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
